// File: rtl/fpu_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : fpu_writeback_stage
// Description : Registered FPU result buffer that formats each result for the
//               register file, with sticky fflags and a commit counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_writeback_stage #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_func7,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [63:0]      in_result,
    input  logic [4:0]       in_flags,
    input  logic             in_cmp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic [63:0]      out_data,
    output logic             out_is_fp,
    output logic [4:0]       out_flags,
    input  logic             csr_we,
    input  logic [4:0]       csr_wdata,
    output logic [4:0]       fflags,
    output logic [31:0]      ops_committed
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_full_count = c_CNT_W'(DEPTH);

    localparam logic [6:0] c_func_fadd_s = 7'b0000000;
    localparam logic [6:0] c_func_fsub_s = 7'b0000100;
    localparam logic [6:0] c_func_fcmp_s = 7'b1010000;
    localparam logic [6:0] c_func_fcmp_d = 7'b1010001;

    logic [TAG_W-1:0]   mem_tag_q   [DEPTH];
    logic [63:0]        mem_data_q  [DEPTH];
    logic               mem_is_fp_q [DEPTH];
    logic [4:0]         mem_flags_q [DEPTH];

    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0] count_q, count_d;
    logic [4:0]         fflags_q, fflags_d;
    logic [31:0]        ops_q, ops_d;

    logic               w_push;
    logic               w_pop;
    logic [63:0]        entry_data_d;
    logic               entry_is_fp_d;
    logic [4:0]         w_head_flags;

    assign in_ready      = (count_q != c_full_count);
    assign out_valid     = (count_q != '0);
    assign w_push        = in_valid && in_ready;
    assign w_pop         = out_valid && out_ready;

    assign out_tag       = mem_tag_q[rd_ptr_q];
    assign out_data      = mem_data_q[rd_ptr_q];
    assign out_is_fp     = mem_is_fp_q[rd_ptr_q];
    assign out_flags     = mem_flags_q[rd_ptr_q];
    assign w_head_flags  = w_pop ? mem_flags_q[rd_ptr_q] : 5'b00000;

    assign fflags        = fflags_q;
    assign ops_committed = ops_q;

    // Results are stored already formatted so the head can drive out_* directly.
    always_comb begin
        entry_data_d  = in_result;
        entry_is_fp_d = 1'b1;
        case (in_func7)
            c_func_fadd_s, c_func_fsub_s: begin
                entry_data_d = {32'hFFFF_FFFF, in_result[31:0]};
            end
            c_func_fcmp_s, c_func_fcmp_d: begin
                entry_data_d  = {63'b0, in_cmp};
                entry_is_fp_d = 1'b0;
            end
            default: begin
                entry_data_d  = in_result;
                entry_is_fp_d = 1'b1;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        fflags_d = fflags_q;
        ops_d    = ops_q;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
            ops_d    = ops_q + 32'd1;
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CNT_W'(1);
            2'b01:   count_d = count_q - c_CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A software write replaces the accrued value but must not lose a retiring entry's flags.
        if (csr_we) begin
            fflags_d = csr_wdata | w_head_flags;
        end else if (w_pop) begin
            fflags_d = fflags_q | w_head_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            fflags_q <= 5'b00000;
            ops_q    <= 32'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            fflags_q <= fflags_d;
            ops_q    <= ops_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_tag_q[wr_ptr_q]   <= in_tag;
            mem_data_q[wr_ptr_q]  <= entry_data_d;
            mem_is_fp_q[wr_ptr_q] <= entry_is_fp_d;
            mem_flags_q[wr_ptr_q] <= in_flags;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_writeback_stage
// Description : Self-checking bench for fpu_writeback_stage: formatting table,
//               directed corner sequences and a randomized queue-model run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_writeback_stage;

    localparam int DEPTH = 2;
    localparam int TAG_W = 5;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [6:0]       in_func7;
    logic [TAG_W-1:0] in_tag;
    logic [63:0]      in_result;
    logic [4:0]       in_flags;
    logic             in_cmp;
    logic             out_valid;
    logic             out_ready;
    logic [TAG_W-1:0] out_tag;
    logic [63:0]      out_data;
    logic             out_is_fp;
    logic [4:0]       out_flags;
    logic             csr_we;
    logic [4:0]       csr_wdata;
    logic [4:0]       fflags;
    logic [31:0]      ops_committed;

    fpu_writeback_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_func7      (in_func7),
        .in_tag        (in_tag),
        .in_result     (in_result),
        .in_flags      (in_flags),
        .in_cmp        (in_cmp),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_tag       (out_tag),
        .out_data      (out_data),
        .out_is_fp     (out_is_fp),
        .out_flags     (out_flags),
        .csr_we        (csr_we),
        .csr_wdata     (csr_wdata),
        .fflags        (fflags),
        .ops_committed (ops_committed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [63:0]      data;
        logic             is_fp;
        logic [4:0]       flags;
    } ent_t;

    typedef struct {
        logic [6:0]  func7;
        logic [63:0] result;
        logic        cmp;
        logic [63:0] exp_data;
        logic        exp_is_fp;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    ent_t        m_q[$];
    logic [4:0]  m_fflags;
    logic [31:0] m_ops;
    vec_t        vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ent_t fmt(input logic [6:0] f7, input logic [TAG_W-1:0] tag,
                                 input logic [63:0] res, input logic cmp, input logic [4:0] fl);
        ent_t e;
        e.tag   = tag;
        e.flags = fl;
        e.is_fp = 1'b1;
        e.data  = res;
        if (f7 == 7'b0000000 || f7 == 7'b0000100) begin
            e.data = {32'hFFFF_FFFF, res[31:0]};
        end else if (f7 == 7'b1010000 || f7 == 7'b1010001) begin
            e.data  = {63'b0, cmp};
            e.is_fp = 1'b0;
        end
        return e;
    endfunction

    // Advance one clock: model reacts to the inputs currently driven, then outputs are compared.
    task automatic step();
        bit         do_push;
        bit         do_pop;
        logic [4:0] hf;
        ent_t       ne;
        do_push = in_valid && (m_q.size() < DEPTH);
        do_pop  = out_ready && (m_q.size() > 0);
        hf      = do_pop ? m_q[0].flags : 5'b00000;
        ne      = fmt(in_func7, in_tag, in_result, in_cmp, in_flags);
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_fflags = 5'b00000;
            m_ops    = 32'd0;
        end else begin
            if (csr_we)      m_fflags = csr_wdata | hf;
            else if (do_pop) m_fflags = m_fflags | hf;
            if (do_pop) begin
                void'(m_q.pop_front());
                m_ops = m_ops + 32'd1;
            end
            if (do_push) m_q.push_back(ne);
        end
        #1;
        chk("model_out_valid", 64'(out_valid), 64'(m_q.size() > 0));
        chk("model_in_ready", 64'(in_ready), 64'(m_q.size() < DEPTH));
        chk("model_fflags", 64'(fflags), 64'(m_fflags));
        chk("model_ops", 64'(ops_committed), 64'(m_ops));
        if (m_q.size() > 0) begin
            chk("model_out_tag", 64'(out_tag), 64'(m_q[0].tag));
            chk("model_out_data", out_data, m_q[0].data);
            chk("model_out_is_fp", 64'(out_is_fp), 64'(m_q[0].is_fp));
            chk("model_out_flags", 64'(out_flags), 64'(m_q[0].flags));
        end
    endtask

    task automatic idle();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        csr_we    = 1'b0;
        csr_wdata = 5'b00000;
        in_func7  = 7'($urandom);
        in_tag    = TAG_W'($urandom);
        in_result = {$urandom, $urandom};
        in_flags  = 5'($urandom);
        in_cmp    = 1'($urandom);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic drive(input logic [6:0] f7, input logic [TAG_W-1:0] tag,
                         input logic [63:0] res, input logic cmp, input logic [4:0] fl);
        in_valid  = 1'b1;
        in_func7  = f7;
        in_tag    = tag;
        in_result = res;
        in_cmp    = cmp;
        in_flags  = fl;
    endtask

    initial begin
        m_q.delete();
        m_fflags = 5'b00000;
        m_ops    = 32'd0;

        vecs[0] = '{7'b0000000, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'hFFFF_FFFF_9ABC_DEF0, 1'b1};
        vecs[1] = '{7'b0000100, 64'h0000_0000_0000_0000, 1'b1, 64'hFFFF_FFFF_0000_0000, 1'b1};
        vecs[2] = '{7'b1010000, 64'hDEAD_BEEF_0000_0000, 1'b1, 64'h0000_0000_0000_0001, 1'b0};
        vecs[3] = '{7'b1010001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0000_0000_0000_0000, 1'b0};
        vecs[4] = '{7'b0000001, 64'h4000_0000_0000_0000, 1'b1, 64'h4000_0000_0000_0000, 1'b1};
        vecs[5] = '{7'b1111111, 64'hCAFE_F00D_1234_5678, 1'b0, 64'hCAFE_F00D_1234_5678, 1'b1};
        vecs[6] = '{7'b1010010, 64'h0000_0000_0000_0055, 1'b1, 64'h0000_0000_0000_0055, 1'b1};
        vecs[7] = '{7'b0001000, 64'h0000_0000_3F80_0000, 1'b1, 64'h0000_0000_3F80_0000, 1'b1};

        // Reset state and SP add
        do_reset();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_fflags", 64'(fflags), 64'd0);
        chk("rst_ops", 64'(ops_committed), 64'd0);
        drive(7'b0000000, 5'd3, 64'h0000_0000_3FC0_0000, 1'b0, 5'b00000);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("spadd_valid", 64'(out_valid), 64'd1);
        chk("spadd_tag", 64'(out_tag), 64'd3);
        chk("spadd_data", out_data, 64'hFFFF_FFFF_3FC0_0000);
        chk("spadd_is_fp", 64'(out_is_fp), 64'd1);
        step();
        chk("spadd_ops", 64'(ops_committed), 64'd1);
        chk("spadd_fflags", 64'(fflags), 64'd0);

        // Compare result goes to the integer file
        drive(7'b1010001, 5'd9, 64'h0, 1'b1, 5'b10000);
        step();
        in_valid = 1'b0;
        chk("cmp_data", out_data, 64'h1);
        chk("cmp_is_fp", 64'(out_is_fp), 64'd0);
        step();
        chk("cmp_fflags", 64'(fflags), 64'b10000);

        // Formatting table
        for (int i = 0; i < 8; i++) begin
            idle();
            drive(vecs[i].func7, TAG_W'(i + 16), vecs[i].result, vecs[i].cmp, 5'(i));
            step();
            idle();
            chk("tbl_data", out_data, vecs[i].exp_data);
            chk("tbl_is_fp", 64'(out_is_fp), 64'(vecs[i].exp_is_fp));
            chk("tbl_tag", 64'(out_tag), 64'(i + 16));
            chk("tbl_flags", 64'(out_flags), 64'(i));
            out_ready = 1'b1;
            step();
        end

        // Full FIFO ignores extra pushes
        idle();
        drive(7'b0000001, 5'd1, 64'h11, 1'b0, 5'b00000);
        step();
        drive(7'b0000001, 5'd2, 64'h22, 1'b0, 5'b00000);
        step();
        chk("full_in_ready", 64'(in_ready), 64'd0);
        drive(7'b0000001, 5'd7, 64'h77, 1'b0, 5'b00000);
        step();
        in_valid = 1'b0;
        chk("full_head_tag", 64'(out_tag), 64'd1);
        out_ready = 1'b1;
        step();
        chk("full_ready_back", 64'(in_ready), 64'd1);
        chk("full_second_tag", 64'(out_tag), 64'd2);
        step();
        chk("full_drained", 64'(out_valid), 64'd0);

        // Simultaneous push/pop keeps one entry in flight
        do_reset();
        drive(7'b0000001, 5'd0, 64'h0, 1'b0, 5'b00000);
        step();
        for (int i = 1; i <= 10; i++) begin
            drive(7'b0000001, TAG_W'(i), 64'(i), 1'b0, 5'b00000);
            out_ready = 1'b1;
            step();
            chk("pp_tag", 64'(out_tag), 64'(i));
            chk("pp_valid_one", 64'(in_ready && out_valid), 64'd1);
        end
        idle();
        chk("pp_ops", 64'(ops_committed), 64'd10);
        out_ready = 1'b1;
        step();

        // CSR write colliding with a pop
        do_reset();
        drive(7'b0000001, 5'd4, 64'h0, 1'b0, 5'b00001);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("csr_pre_fflags", 64'(fflags), 64'b00001);
        idle();
        drive(7'b0000001, 5'd5, 64'h0, 1'b0, 5'b01000);
        step();
        idle();
        csr_we    = 1'b1;
        csr_wdata = 5'b00100;
        out_ready = 1'b1;
        step();
        idle();
        chk("csr_collide", 64'(fflags), 64'b01100);

        // Reset in the middle of operation
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(7'b0000001, TAG_W'(i), 64'h0, 1'b0, 5'b11111);
            step();
            idle();
            out_ready = 1'b1;
            step();
            idle();
        end
        drive(7'b0000001, 5'd20, 64'h0, 1'b0, 5'b00000);
        step();
        drive(7'b0000001, 5'd21, 64'h0, 1'b0, 5'b00000);
        step();
        idle();
        chk("mid_pre_fflags", 64'(fflags), 64'b11111);
        chk("mid_pre_ops", 64'(ops_committed), 64'd5);
        do_reset();
        chk("mid_out_valid", 64'(out_valid), 64'd0);
        chk("mid_in_ready", 64'(in_ready), 64'd1);
        chk("mid_fflags", 64'(fflags), 64'd0);
        chk("mid_ops", 64'(ops_committed), 64'd0);
        drive(7'b0000001, 5'd6, 64'h4000_0000_0000_0000, 1'b0, 5'b00000);
        step();
        idle();
        chk("mid_dp_data", out_data, 64'h4000_0000_0000_0000);

        // Randomized traffic against the queue model
        for (int i = 0; i < 3000; i++) begin
            idle();
            rst       = ($urandom_range(0, 199) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            csr_we    = ($urandom_range(0, 9) == 0);
            csr_wdata = 5'($urandom);
            case ($urandom_range(0, 5))
                0: in_func7 = 7'b0000000;
                1: in_func7 = 7'b0000100;
                2: in_func7 = 7'b1010000;
                3: in_func7 = 7'b1010001;
                default: in_func7 = 7'($urandom);
            endcase
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpu_writeback_stage.md
Name: fpu_writeback_stage

Overview:
Registered output stage directly downstream of the combinational FPU top. It captures each FPU result with its destination tag and formats it for the register file:
- NaN-boxes single-precision results.
- Converts compare results to integer writes.

It buffers results in a small FIFO with a valid/ready handshake toward the writeback port. It also maintains the sticky accrued-exception register (fflags) and a committed-operation counter.

Parameters:
DEPTH, 2, number of buffered results (power of two, >=2)
TAG_W, 5, destination register tag width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
in_valid  in  1  FPU result valid this cycle
in_ready  out  1  stage can accept a result; equals !full, taken from registered count
in_func7  in  7  opcode that produced the result
in_tag  in  TAG_W  destination register index
in_result  in  64  FPU result_out
in_flags  in  5  {invalid, divbyzero, overflow, underflow, inexact} from FPU
in_cmp  in  1  FPU flag_cmp
out_valid  out  1  head entry valid
out_ready  in  1  writeback port accepts head
out_tag  out  TAG_W  head destination tag
out_data  out  64  head formatted data
out_is_fp  out  1  1 = FP register file, 0 = integer register file
out_flags  out  5  head exception flags
csr_we  in  1  software write of fflags
csr_wdata  in  5  fflags write value
fflags  out  5  sticky accrued flags {NV,DZ,OF,UF,NX}
ops_committed  out  32  count of popped entries

Behaviour:
- Reset (rst=1 at a clock edge):
  - count=0, read/write pointers=0, so out_valid=0 and in_ready=1.
  - fflags=0, ops_committed=0.
  - Entry contents are don't-care.
  - Reset mid-operation discards all buffered entries.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- Formatting is applied at push time. The stored entry holds the formatted values.
  - func7 = 0000000 or 0000100 (FADD_S/FSUB_S):
    - data = {32'hFFFF_FFFF, in_result[31:0]}
    - is_fp = 1
  - func7 = 1010000 or 1010001 (FCMP_S/FCMP_D):
    - data = {63'b0, in_cmp}
    - is_fp = 0
  - All other func7, including the FPU's invalid-opcode default: data = in_result unmodified, is_fp = 1.
  - flags = in_flags in every case.
- Latency: an entry pushed at edge N is visible on out_* after edge N (out_valid=1 in cycle N+1). There is no combinational path from in_* to out_*.
- Output order: FIFO order.
  - out_* show the head entry and remain stable while out_valid && !out_ready.
- Full (count==DEPTH): in_ready=0, and in_valid is ignored. in_ready does not depend on out_ready in the same cycle.
- Empty (count==0): out_valid=0. out_ready is ignored and causes no pop, counter change or flag update.
- Simultaneous push and pop (non-empty, not full): count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- fflags update per edge, highest priority first:
  - rst → 0.
  - csr_we → csr_wdata | (pop ? head flags : 0).
  - pop → fflags | head flags.
  - Otherwise hold.
- Flags accrue only on pop. A pushed but unpopped entry does not affect fflags.
- ops_committed increments by 1 on each pop and wraps from 32'hFFFF_FFFF to 0.
- X-safety: in_func7, in_result, in_flags and in_cmp are not sampled when no push occurs.

Test Plan:
- Reset then SP add: push func7=0000000, tag=3, result=64'h0000_0000_3FC0_0000, flags=0, out_ready=1.
  → next cycle out_valid=1, out_tag=3, out_data=64'hFFFF_FFFF_3FC0_0000, out_is_fp=1.
  → after pop, ops_committed=1, fflags=0.
- Compare: push func7=1010001, cmp=1, flags=5'b10000.
  → out_data=64'h1, out_is_fp=0.
  → after pop, fflags=5'b10000.
- Backpressure/full, DEPTH=2: hold out_ready=0 and push 2 entries (tags 1, 2).
  → in_ready=0; a third in_valid with tag 7 is ignored.
  → raise out_ready: tags 1 then 2 pop in order, tag 7 never appears, and in_ready returns to 1 the cycle after the first pop.
- Simultaneous push/pop: with 1 entry buffered, push and pop in the same cycle for 10 cycles.
  → count stays 1, tags are delivered in order, ops_committed=10.
- CSR collision: fflags=5'b00001, csr_we=1 with csr_wdata=5'b00100 in the same cycle as popping an entry with flags 5'b01000.
  → fflags=5'b01100.
- Reset mid-operation: with 2 entries buffered, fflags=5'b11111 and ops_committed=5, assert rst for one cycle.
  → out_valid=0, in_ready=1, fflags=0, ops_committed=0.
  → a subsequent push of DP add result 64'h4000_0000_0000_0000 is delivered unmodified.
